// File: rtl/cfu_flex_fifo.sv
// Synchronous FIFO with arbitrary depth, optional fall-through when empty,
// almost-full threshold and sticky overflow/underflow flags.
module cfu_flex_fifo #(
  parameter int DATA_WIDTH   = 70,
  parameter int DEPTH        = 4,
  parameter int AF_THRESHOLD = DEPTH - 1,
  parameter int BYPASS       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid,
  output logic                         full,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  empty, is_full, byp_push, byp_thru, push_acc, pop_acc;

  // With DEPTH==1 the compare is against 0, so pointers stay constant 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));
    byp_push = (BYPASS != 0) && push && !rst;
    byp_thru = byp_push && pop && empty;
    push_acc = push && !rst && !flush && (!is_full || pop) && !byp_thru;
    pop_acc  = pop && !rst && !flush && !empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_acc) - CW'(pop_acc);
      ovf_d   = ovf_q | (push && is_full && !pop);
      unf_d   = unf_q | (pop && empty && !byp_push);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is never reset; the output mux below hides it while empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_in;
  end

  always_comb begin
    valid = !empty || byp_push;
    if (!empty)        data_out = mem_q[rd_ptr_q];
    else if (byp_push) data_out = data_in;
    else               data_out = '0;
  end

  assign full          = is_full;
  assign almost_full   = (count_q >= CW'(AF_THRESHOLD));
  assign count         = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: doc/cfu_flex_fifo.md
CFU_FLEX_FIFO -- requirements
Module: cfu_flex_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 70, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count (>=1, any integer, not forced to a power of 2).
REQ-003 SHALL have parameter AF_THRESHOLD, default DEPTH-1, almost-full level (1..DEPTH).
REQ-004 SHALL have parameter BYPASS, default 0, 1 = fall-through when empty.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  discard all contents and clear error flags.
REQ-009 push  input  1  enqueue data_in this cycle.
REQ-010 data_in  input  DATA_WIDTH  enqueue payload.
REQ-011 pop  input  1  dequeue head this cycle.
REQ-012 data_out  output  DATA_WIDTH  head payload.
REQ-013 valid  output  1  data_out holds a valid entry.
REQ-014 full  output  1  count == DEPTH.
REQ-015 almost_full  output  1  count >= AF_THRESHOLD.
REQ-016 count  output  $clog2(DEPTH+1)  stored entries.
REQ-017 overflow_err  output  1  sticky: a push was dropped.
REQ-018 underflow_err  output  1  sticky: a pop hit an empty FIFO.

Function
REQ-019 Storage SHALL be DEPTH entries addressed by binary read/write pointers; each pointer SHALL wrap from DEPTH-1 to 0.
REQ-020 Accepted push SHALL write data_in at write pointer and advance it; accepted pop SHALL advance read pointer; count SHALL change by +1, -1 or 0 in the next cycle.
REQ-021 Push when full and pop=0 SHALL be dropped (no write, pointers and count unchanged) and set overflow_err next cycle.
REQ-022 Push and pop together when full SHALL both be accepted; count stays DEPTH.
REQ-023 Pop when empty (and not bypassed) SHALL be ignored and set underflow_err next cycle.
REQ-024 Push and pop together with 0<count<DEPTH SHALL both be accepted; count unchanged.
REQ-025 BYPASS=0: valid = (count != 0); data_out = head entry when valid, 0 otherwise; push-to-valid latency 1 cycle.
REQ-026 BYPASS=1: valid = (count != 0) | push; when count == 0, data_out = data_in combinationally (0-cycle latency).
REQ-027 BYPASS=1, count==0, push & pop: data passes through, nothing written, count stays 0, no underflow_err.
REQ-028 BYPASS=1, count==0, push & ~pop: entry written, count becomes 1.
REQ-029 flush SHALL take priority over push/pop: next cycle count=0, both pointers=0, overflow_err=0, underflow_err=0; same-cycle push/pop ignored.
REQ-030 full, almost_full SHALL derive combinationally from registered count only.
REQ-031 Error flags SHALL stay set until flush or rst.
REQ-032 DEPTH==1 SHALL be supported with pointers degenerate (constant 0).
REQ-033 Storage contents SHALL not require reset; data_out SHALL never expose stale storage while valid=0.

Reset
REQ-034 rst asserted SHALL immediately force count=0, pointers=0, valid=0 (BYPASS=0), full=0, almost_full=0, data_out=0, overflow_err=0, underflow_err=0.
REQ-035 rst asserted mid-operation SHALL discard all contents; first push after rst deasserts SHALL appear as the head.
REQ-036 While rst is high, push/pop/flush SHALL have no effect.

Verification
REQ-037 DEPTH=3, BYPASS=0: push A,B,C -> count=3, full=1, almost_full=1; pop x3 -> data_out A,B,C in order, count=0, valid=0.
REQ-038 DEPTH=3: fill, then 5 cycles push&pop with D..H -> count stays 3, output order continues A..E, pointers wrap, no errors.
REQ-039 DEPTH=3 full: push alone -> overflow_err=1, count=3, data unchanged; empty pop -> underflow_err=1; flush -> both flags 0, count=0.
REQ-040 BYPASS=1, empty: push=1, pop=1, data_in=0x5A -> data_out=0x5A, valid=1 same cycle, count stays 0.
REQ-041 DEPTH=4, AF_THRESHOLD=2: push 2 -> almost_full=1, full=0; assert rst async mid-cycle with count=2 -> count=0, valid=0 immediately.
REQ-042 Flush with simultaneous push at count=2 -> next cycle count=0, valid=0, pushed word discarded.
